// File: rtl/reduce_pipe_if.sv
// rtl/reduce_pipe_if.sv - valid/ready stream bundle for reduce_pipe
// Operand beats in, one-bit frame results out.
interface reduce_pipe_if #(
  parameter int width = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [width-1:0] a;
  logic [1:0]       mode;
  logic             invert;
  logic             last;
  logic             out_valid;
  logic             out_ready;
  logic             y;
  logic [7:0]       beats;

  modport master (
    output in_valid, a, mode, invert, last, out_ready,
    input  in_ready, out_valid, y, beats
  );

  modport slave (
    input  in_valid, a, mode, invert, last, out_ready,
    output in_ready, out_valid, y, beats
  );
endinterface

// File: rtl/reduce_pipe.sv
// rtl/reduce_pipe.sv - pipelined AND/OR/XOR bit reduction with frame accumulation
// Registered fanin-ary tree feeding a frame accumulator and a single output register.
module reduce_pipe #(
  parameter int width = 8,
  parameter int fanin = 4
) (
  input logic          clk,
  input logic          reset,
  reduce_pipe_if.slave bus
);

  function automatic int calc_stages();
    int s;
    int p;
    s = 0;
    p = 1;
    while (p < width) begin
      p = p * fanin;
      s = s + 1;
    end
    return s;
  endfunction

  function automatic int cnt_at(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * fanin;
    return (width + p - 1) / p;
  endfunction

  function automatic int off_at(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s = s + cnt_at(i);
    return s;
  endfunction

  function automatic logic ident_f(input logic [1:0] m);
    return !(m == 2'b01 || m == 2'b10);
  endfunction

  function automatic logic reduce_f(input logic [1:0] m, input logic [fanin-1:0] v);
    case (m)
      2'b01:   return |v;
      2'b10:   return ^v;
      default: return &v;
    endcase
  endfunction

  function automatic logic combine_f(input logic [1:0] m, input logic x, input logic z);
    case (m)
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return x & z;
    endcase
  endfunction

  localparam int STAGES = calc_stages();
  localparam int TOT    = off_at(STAGES + 1);
  localparam int TAIL   = off_at(STAGES);

  // Slot 0 of every flattened array is the input port; slot k is tree level k.
  logic [TOT-1:0]        pv;
  logic [STAGES:0]       lv_v;
  logic [STAGES:0]       lv_last;
  logic [STAGES:0]       lv_inv;
  logic [2*STAGES+1:0]   lv_mode;
  logic [STAGES:1]       adv;
  logic                  absorb;

  assign pv[width-1:0] = bus.a;
  assign lv_v[0]       = bus.in_valid;
  assign lv_last[0]    = bus.last;
  assign lv_inv[0]     = bus.invert;
  assign lv_mode[1:0]  = bus.mode;

  for (genvar k = 1; k <= STAGES; k++) begin : g_lvl
    localparam int NP    = cnt_at(k - 1);
    localparam int NK    = cnt_at(k);
    localparam int OFS_P = off_at(k - 1);
    localparam int OFS_K = off_at(k);

    logic [1:0]    pm;
    logic [NK-1:0] nd;
    logic [NK-1:0] part_q;
    logic          v_q;
    logic          last_q;
    logic          inv_q;
    logic [1:0]    mode_q;

    assign pm = lv_mode[2*(k-1) +: 2];

    for (genvar i = 0; i < NK; i++) begin : g_node
      logic [fanin-1:0] ins;
      for (genvar j = 0; j < fanin; j++) begin : g_in
        if (i * fanin + j < NP) begin : g_live
          assign ins[j] = pv[OFS_P + i*fanin + j];
        end else begin : g_pad
          assign ins[j] = ident_f(pm);
        end
      end
      assign nd[i] = reduce_f(pm, ins);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q    <= 1'b0;
        part_q <= '0;
        last_q <= 1'b0;
        inv_q  <= 1'b0;
        mode_q <= 2'b00;
      end else if (adv[k]) begin
        v_q    <= lv_v[k-1];
        part_q <= nd;
        last_q <= lv_last[k-1];
        inv_q  <= lv_inv[k-1];
        mode_q <= pm;
      end
    end

    assign pv[OFS_K +: NK]   = part_q;
    assign lv_v[k]           = v_q;
    assign lv_last[k]        = last_q;
    assign lv_inv[k]         = inv_q;
    assign lv_mode[2*k +: 2] = mode_q;

    if (k < STAGES) begin : g_mid
      assign adv[k] = !v_q || adv[k+1];
    end else begin : g_tail
      assign adv[k] = !v_q || absorb;
    end
  end

  logic       t_r;
  logic       t_v;
  logic       t_last;
  logic       t_inv;
  logic [1:0] t_mode;

  assign t_r    = pv[TAIL];
  assign t_v    = lv_v[STAGES];
  assign t_last = lv_last[STAGES];
  assign t_inv  = lv_inv[STAGES];
  assign t_mode = lv_mode[2*STAGES +: 2];

  logic       acc_q, acc_d;
  logic [1:0] frame_mode_q, frame_mode_d;
  logic       frame_inv_q, frame_inv_d;
  logic       in_frame_q, in_frame_d;
  logic [7:0] count_q, count_d;
  logic       out_valid_q, out_valid_d;
  logic       y_q, y_d;
  logic [7:0] beats_q, beats_d;

  logic       res;
  logic       eff_inv;
  logic [1:0] eff_mode;
  logic [7:0] cnt_nxt;

  // A last beat needs a free output slot; non-last beats only touch the accumulator.
  assign absorb = t_v && (!t_last || !out_valid_q || bus.out_ready);

  always_comb begin
    eff_mode     = in_frame_q ? frame_mode_q : t_mode;
    eff_inv      = in_frame_q ? frame_inv_q : t_inv;
    res          = in_frame_q ? combine_f(frame_mode_q, acc_q, t_r) : t_r;
    cnt_nxt      = !in_frame_q ? 8'd1 : (count_q == 8'hFF ? 8'hFF : count_q + 8'd1);
    acc_d        = acc_q;
    frame_mode_d = frame_mode_q;
    frame_inv_d  = frame_inv_q;
    in_frame_d   = in_frame_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    y_d          = y_q;
    beats_d      = beats_q;
    if (absorb) begin
      if (t_last) begin
        out_valid_d = 1'b1;
        y_d         = res ^ eff_inv;
        beats_d     = cnt_nxt;
        in_frame_d  = 1'b0;
        count_d     = cnt_nxt;
      end else begin
        acc_d        = res;
        frame_mode_d = eff_mode;
        frame_inv_d  = eff_inv;
        count_d      = cnt_nxt;
        in_frame_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= 1'b0;
      frame_mode_q <= 2'b00;
      frame_inv_q  <= 1'b0;
      in_frame_q   <= 1'b0;
      count_q      <= 8'd0;
      out_valid_q  <= 1'b0;
      y_q          <= 1'b0;
      beats_q      <= 8'd0;
    end else begin
      acc_q        <= acc_d;
      frame_mode_q <= frame_mode_d;
      frame_inv_q  <= frame_inv_d;
      in_frame_q   <= in_frame_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      y_q          <= y_d;
      beats_q      <= beats_d;
    end
  end

  assign bus.in_ready  = adv[1] && !reset;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.beats     = beats_q;

endmodule
